// File: rtl/fp_normalize_stage_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared definitions for the floating-point add pipeline:
//               default field widths, exponent saturation value, the
//               normalizer state encoding and the packed FP word layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int MANT_W_DEFAULT = 8;
    localparam int EXP_W_DEFAULT  = 3;
    localparam int EXP_MAX        = (2 ** EXP_W_DEFAULT) - 1;

    // Normalizer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } norm_state_t;

    // Packed floating-point word shared by the adder and normalizer stages
    typedef struct packed {
        logic                      sign;
        logic [EXP_W_DEFAULT-1:0]  exponent;
        logic [MANT_W_DEFAULT-1:0] mantissa;
    } fp_word_t;

endpackage

`default_nettype wire

// File: rtl/fp_normalize_stage_if.sv
// ============================================================================
// Module      : fp_normalize_stage_if
// Description : Handshake and data bundle between the FP adder (master side)
//               and the post-add normalization stage (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_normalize_stage_if #(
    parameter int MANT_W = fp_pkg::MANT_W_DEFAULT,
    parameter int EXP_W  = fp_pkg::EXP_W_DEFAULT
);
    // Upstream side: raw adder sum
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W:0]   raw_mantissa;
    logic [EXP_W-1:0]  raw_exponent;
    logic              raw_sign;

    // Downstream side: normalized result
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] norm_mantissa;
    logic [EXP_W-1:0]  norm_exponent;
    logic              norm_sign;
    logic              overflow;
    logic              underflow;
    logic [2:0]        shift_count;

    // Producer of raw sums and consumer of normalized results
    modport master (
        output in_valid, raw_mantissa, raw_exponent, raw_sign, out_ready,
        input  in_ready, out_valid, norm_mantissa, norm_exponent, norm_sign,
               overflow, underflow, shift_count
    );

    // The normalization stage itself
    modport slave (
        input  in_valid, raw_mantissa, raw_exponent, raw_sign, out_ready,
        output in_ready, out_valid, norm_mantissa, norm_exponent, norm_sign,
               overflow, underflow, shift_count
    );

endinterface

`default_nettype wire

// File: rtl/fp_normalize_stage_round.sv
// ============================================================================
// Module      : fp_round_nearest_even
// Description : Combinational conditional increment with carry-out, used to
//               round the mantissa after the carry right-shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_nearest_even #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic             i_inc,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_carry
);

    // Increment by one when requested; carry flags a wrap to zero
    assign {o_carry, o_sum} = {1'b0, i_a} + {{WIDTH{1'b0}}, i_inc};

endmodule

`default_nettype wire

// File: rtl/fp_normalize_stage.sv
// ============================================================================
// Module      : fp_normalize_stage
// Description : Post-add normalization. Classifies the raw adder sum on
//               accept, then left-shifts one bit per cycle until the leading
//               one reaches the MSB or the exponent bottoms out. Carry-out
//               sums are right-shifted once with exponent saturation.
//               Optional build macro FP_NORM_ROUND_EN: round-to-nearest-even
//               on the carry right-shift (truncation when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_normalize_stage
    import fp_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEFAULT,
    parameter int EXP_W  = EXP_W_DEFAULT
) (
    input wire logic             clk,
    input wire logic             rst_n,
    fp_normalize_stage_if.slave  bus
);

    localparam logic [EXP_W-1:0]  C_EXP_SAT  = {EXP_W{1'b1}};
    localparam logic [MANT_W-1:0] C_MANT_SAT = {MANT_W{1'b1}};

    norm_state_t       state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [2:0]        shcnt_q, shcnt_d;

    // Mantissa after dropping the carry-stage LSB (rounded or truncated)
    logic [MANT_W-1:0] w_carry_mant;
    logic [MANT_W-1:0] w_shift_mant;
    logic [EXP_W-1:0]  w_shift_exp;

`ifdef FP_NORM_ROUND_EN
    logic w_rnd_wrap;

    fp_round_nearest_even #(
        .WIDTH (MANT_W)
    ) u_round (
        .i_a     (bus.raw_mantissa[MANT_W:1]),
        .i_inc   (bus.raw_mantissa[1] & bus.raw_mantissa[0]),
        .o_sum   (w_carry_mant),
        .o_carry (w_rnd_wrap)
    );
`else
    assign w_carry_mant = bus.raw_mantissa[MANT_W:1];
`endif

    assign w_shift_mant = {mant_q[MANT_W-2:0], 1'b0};
    assign w_shift_exp  = exp_q - 1'b1;

    // State and result registers; reset discards any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            shcnt_q <= 3'd0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            shcnt_q <= shcnt_d;
        end
    end

    // Classification on accept, iterative shifting, and retirement
    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        shcnt_d = shcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_DONE;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    shcnt_d = 3'd0;
                    sign_d  = bus.raw_sign;
                    exp_d   = bus.raw_exponent;
                    mant_d  = bus.raw_mantissa[MANT_W-1:0];

                    if (bus.raw_mantissa == '0) begin
                        // Exact cancellation always yields positive zero
                        mant_d = '0;
                        exp_d  = '0;
                        sign_d = 1'b0;
                    end else if (bus.raw_mantissa[MANT_W]) begin
                        if (bus.raw_exponent == C_EXP_SAT) begin
                            ovf_d  = 1'b1;
                            mant_d = C_MANT_SAT;
                        end else begin
                            mant_d = w_carry_mant;
                            exp_d  = bus.raw_exponent + 1'b1;
`ifdef FP_NORM_ROUND_EN
                            // Rounding carried out of the MSB: renormalize again
                            if (w_rnd_wrap) begin
                                if (exp_d == C_EXP_SAT) begin
                                    ovf_d  = 1'b1;
                                    mant_d = C_MANT_SAT;
                                end else begin
                                    mant_d = {1'b1, {(MANT_W-1){1'b0}}};
                                    exp_d  = exp_d + 1'b1;
                                end
                            end
`endif
                        end
                    end else if (bus.raw_mantissa[MANT_W-1]) begin
                        // Already normalized: pass through
                    end else if (bus.raw_exponent == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                mant_d  = w_shift_mant;
                exp_d   = w_shift_exp;
                shcnt_d = shcnt_q + 3'd1;
                if (w_shift_mant[MANT_W-1]) begin
                    state_d = ST_DONE;
                end else if (w_shift_exp == '0) begin
                    state_d = ST_DONE;
                    unf_d   = 1'b1;
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready      = (state_q == ST_IDLE);
    assign bus.out_valid     = (state_q == ST_DONE);
    assign bus.norm_mantissa = mant_q;
    assign bus.norm_exponent = exp_q;
    assign bus.norm_sign     = sign_q;
    assign bus.overflow      = ovf_q;
    assign bus.underflow     = unf_q;
    assign bus.shift_count   = shcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_normalize_stage.sv
// ============================================================================
// Module      : tb_fp_normalize_stage
// Description : Self-checking bench for fp_normalize_stage: directed vectors,
//               randomized sums with random backpressure, and mid-shift reset,
//               compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_normalize_stage;
    import fp_pkg::*;

    localparam int MW = MANT_W_DEFAULT;
    localparam int EW = EXP_W_DEFAULT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fp_normalize_stage_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

    fp_normalize_stage #(.MANT_W(MW), .EXP_W(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int last_mant;
    int last_exp;

    // Count a comparison and report any mismatch
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: normalization by value arithmetic
    function automatic void model(input int raw, input int e, input int s,
                                  output int m, output int oe, output int os,
                                  output int ov, output int un, output int sh);
        int need;
        int v;
        m = 0; oe = 0; os = s; ov = 0; un = 0; sh = 0;
        if (raw == 0) begin
            os = 0;
        end else if (raw >= 256) begin
            if (e == EXP_MAX) begin
                ov = 1; m = 255; oe = e;
            end else begin
                m  = raw / 2;
                oe = e + 1;
`ifdef FP_NORM_ROUND_EN
                if (raw % 4 == 3) m = m + 1;
                if (m == 256) begin
                    m  = 128;
                    oe = oe + 1;
                end
                if (oe > EXP_MAX) begin
                    ov = 1; m = 255; oe = EXP_MAX;
                end
`endif
            end
        end else begin
            need = 0;
            v    = raw;
            while (v < 128) begin
                v    = v * 2;
                need = need + 1;
            end
            sh = (need < e) ? need : e;
            m  = raw * (2 ** sh);
            oe = e - sh;
            un = (sh < need) ? 1 : 0;
        end
    endfunction

    // One full transaction starting at a negedge with the DUT idle
    task automatic run_txn(input int raw, input int e, input int s, input int hold);
        int m, oe, os, ov, un, sh, lat;
        logic [31:0] rv;
        logic [31:0] ev;
        model(raw, e, s, m, oe, os, ov, un, sh);
        rv = raw;
        ev = e;
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid     = 1'b1;
        bus.raw_mantissa = rv[MW:0];
        bus.raw_exponent = ev[EW-1:0];
        bus.raw_sign     = s[0];
        @(posedge clk);
        @(negedge clk);
        bus.in_valid     = 1'b0;
        bus.raw_mantissa = 9'($urandom);
        bus.raw_exponent = 3'($urandom);
        bus.raw_sign     = 1'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 1 + sh);
        check("mant", {24'd0, bus.norm_mantissa}, m);
        check("exp", {29'd0, bus.norm_exponent}, oe);
        check("sign", {31'd0, bus.norm_sign}, os);
        check("overflow", {31'd0, bus.overflow}, ov);
        check("underflow", {31'd0, bus.underflow}, un);
        check("shift_count", {29'd0, bus.shift_count}, sh);
        last_mant = int'(bus.norm_mantissa);
        last_exp  = int'(bus.norm_exponent);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("hold_mant", {24'd0, bus.norm_mantissa}, m);
            check("hold_exp", {29'd0, bus.norm_exponent}, oe);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("retire_valid", {31'd0, bus.out_valid}, 32'd0);
        check("retire_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int raw;
        int e;
        bus.in_valid     = 1'b0;
        bus.raw_mantissa = '0;
        bus.raw_exponent = '0;
        bus.raw_sign     = 1'b0;
        bus.out_ready    = 1'b0;

        // Reset values
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_mant", {24'd0, bus.norm_mantissa}, 32'd0);
        check("rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        check("rst_shift_count", {29'd0, bus.shift_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_txn(9'h080, 3, 1, 3);
        run_txn(9'h1A7, 2, 0, 0);
`ifdef FP_NORM_ROUND_EN
        check("round_1A7_mant", last_mant, 32'hD4);
`else
        check("trunc_1A7_mant", last_mant, 32'hD3);
`endif
        check("carry_1A7_exp", last_exp, 32'd3);
        run_txn(9'h005, 6, 0, 1);
        check("shift_005_mant", last_mant, 32'hA0);
        run_txn(9'h003, 2, 0, 0);
        run_txn(9'h100, 7, 1, 2);
        run_txn(9'h000, 5, 1, 0);
        run_txn(9'h1FF, 5, 0, 0);
        run_txn(9'h1FF, 6, 1, 0);
        run_txn(9'h040, 0, 0, 0);
        run_txn(9'h001, 7, 0, 0);

        // Reset asserted in the middle of shifting
        bus.in_valid     = 1'b1;
        bus.raw_mantissa = 9'h005;
        bus.raw_exponent = 3'd6;
        bus.raw_sign     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid_rst_shift_count", {29'd0, bus.shift_count}, 32'd0);
        check("mid_rst_mant", {24'd0, bus.norm_mantissa}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Randomized sums with random backpressure
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       raw = int'($urandom_range(0, 15));
                1:       raw = int'($urandom_range(256, 511));
                default: raw = int'($urandom_range(0, 511));
            endcase
            e = int'($urandom_range(0, EXP_MAX));
            run_txn(raw, e, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
